// File: rtl/ir_mdr_unit_pkg.sv
// irmdr_pkg: channel state, MIPS IR field positions and default timeout for ir_mdr_unit.
package irmdr_pkg;
  typedef enum logic {IDLE, WAIT} chan_state_e;
  localparam int DEF_TIMEOUT = 16;
  localparam int OPC_LSB = 26;
  localparam int OPC_W   = 6;
  localparam int RS_LSB  = 21;
  localparam int RT_LSB  = 16;
  localparam int RD_LSB  = 11;
  localparam int SH_LSB  = 6;
  localparam int REG_W   = 5;
  localparam int FN_LSB  = 0;
  localparam int FN_W    = 6;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = 16;
endpackage

// File: rtl/ir_mdr_unit_if.sv
// ir_mdr_unit_if: control, memory-channel and decode signals of ir_mdr_unit; master is the unit side.
interface ir_mdr_unit_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              ir_write;
  logic [ADDR_W-1:0] pc_addr;
  logic              mdr_write;
  logic [ADDR_W-1:0] data_addr;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              imem_valid;
  logic              dmem_req;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_valid;
  logic              ir_busy;
  logic              mdr_busy;
  logic              ir_done;
  logic              mdr_done;
  logic [1:0]        fault;
  logic [5:0]        opcode;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic [5:0]        funct;
  logic [15:0]       imm;
  logic [DATA_W-1:0] mdr;
  modport master (
    input  ir_write, pc_addr, mdr_write, data_addr, imem_rdata, imem_valid, dmem_rdata, dmem_valid,
    output imem_req, imem_addr, dmem_req, dmem_addr, ir_busy, mdr_busy, ir_done, mdr_done, fault,
           opcode, rs, rt, rd, shamt, funct, imm, mdr
  );
  modport slave (
    output ir_write, pc_addr, mdr_write, data_addr, imem_rdata, imem_valid, dmem_rdata, dmem_valid,
    input  imem_req, imem_addr, dmem_req, dmem_addr, ir_busy, mdr_busy, ir_done, mdr_done, fault,
           opcode, rs, rt, rd, shamt, funct, imm, mdr
  );
endinterface

// File: rtl/ir_mdr_unit_chan.sv
// mem_capture_chan: one request/valid read channel with timeout abort, sticky fault and captured data word.
module mem_capture_chan
  import irmdr_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  output logic              req,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rdata,
  input  logic              valid,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [DATA_W-1:0] data
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  chan_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              done_q, done_d;
  logic              fault_q, fault_d;
  logic              launch, hit, expire;
  always_comb begin
    launch  = state_q == IDLE && start;
    hit     = state_q == WAIT && valid;
    // this edge is the TIMEOUT-th one spent waiting; a late valid still wins
    expire  = state_q == WAIT && !valid && cnt_q == CNT_W'(TIMEOUT - 1);
    state_d = launch ? WAIT : (hit || expire) ? IDLE : state_q;
    cnt_d   = launch ? '0 : (state_q == WAIT && cnt_q != CNT_W'(TIMEOUT)) ? cnt_q + 1'b1 : cnt_q;
    addr_d  = launch ? start_addr : addr_q;
    data_d  = hit ? rdata : data_q;
    done_d  = hit;
    fault_d = fault_q | expire;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end
  assign req   = state_q == WAIT;
  assign busy  = state_q == WAIT;
  assign addr  = addr_q;
  assign done  = done_q;
  assign fault = fault_q;
  assign data  = data_q;
endmodule

// File: rtl/ir_mdr_unit.sv
// ir_mdr_unit: IR/MDR stage with independent instruction and data fetch channels and MIPS field decode.
// IRMDR_PERF_EN adds fetch_count / stall_count performance counters.
module ir_mdr_unit
  import irmdr_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
`ifdef IRMDR_PERF_EN
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count,
`endif
  ir_mdr_unit_if.master bus
);
  logic [31:0] ir;
  logic [1:0]  flt;
  mem_capture_chan #(.ADDR_W(ADDR_W), .DATA_W(32), .TIMEOUT(TIMEOUT)) u_ir (
    .clk(clk), .reset(reset), .start(bus.ir_write), .start_addr(bus.pc_addr),
    .req(bus.imem_req), .addr(bus.imem_addr), .rdata(bus.imem_rdata), .valid(bus.imem_valid),
    .busy(bus.ir_busy), .done(bus.ir_done), .fault(flt[0]), .data(ir)
  );
  mem_capture_chan #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) u_mdr (
    .clk(clk), .reset(reset), .start(bus.mdr_write), .start_addr(bus.data_addr),
    .req(bus.dmem_req), .addr(bus.dmem_addr), .rdata(bus.dmem_rdata), .valid(bus.dmem_valid),
    .busy(bus.mdr_busy), .done(bus.mdr_done), .fault(flt[1]), .data(bus.mdr)
  );
  assign bus.fault  = flt;
  assign bus.opcode = ir[OPC_LSB +: OPC_W];
  assign bus.rs     = ir[RS_LSB +: REG_W];
  assign bus.rt     = ir[RT_LSB +: REG_W];
  assign bus.rd     = ir[RD_LSB +: REG_W];
  assign bus.shamt  = ir[SH_LSB +: REG_W];
  assign bus.funct  = ir[FN_LSB +: FN_W];
  assign bus.imm    = ir[IMM_LSB +: IMM_W];
`ifdef IRMDR_PERF_EN
  logic [31:0] fetch_q, stall_q;
  // count the capture edge itself so the total is current alongside ir_done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_q <= '0;
      stall_q <= '0;
    end else begin
      fetch_q <= fetch_q + 32'(bus.ir_busy && bus.imem_valid);
      stall_q <= stall_q + 32'(bus.ir_busy);
    end
  end
  assign fetch_count = fetch_q;
  assign stall_count = stall_q;
`endif
endmodule

// File: tb/tb_ir_mdr_unit.sv
// tb_ir_mdr_unit: directed literal checks plus randomized traffic against a cycle-count reference model.
module tb_ir_mdr_unit;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  ir_mdr_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
`ifdef IRMDR_PERF_EN
  logic [31:0] fetch_count, stall_count;
`endif
  ir_mdr_unit #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk),
    .reset(reset),
`ifdef IRMDR_PERF_EN
    .fetch_count(fetch_count),
    .stall_count(stall_count),
`endif
    .bus(bus)
  );
  int n_pass = 0;
  int n_total = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  // reference model: a pending access remembers the edge it launched on;
  // it completes on the first valid or aborts TO edges after launch
  bit          m_busy[2];
  int          m_start[2];
  logic [31:0] m_addr[2];
  logic [31:0] m_data[2];
  bit          m_done[2];
  bit          m_fault[2];
  logic [31:0] m_fetch, m_stall;
  int          edge_n = 0;
  function automatic void step(input int c, input logic st, input logic [31:0] a,
                               input logic v, input logic [31:0] d);
    m_done[c] = 1'b0;
    if (m_busy[c]) begin
      if (v) begin
        m_data[c] = d;
        m_done[c] = 1'b1;
        m_busy[c] = 1'b0;
        if (c == 0) m_fetch = m_fetch + 1;
      end else if (edge_n - m_start[c] >= TO) begin
        m_busy[c]  = 1'b0;
        m_fault[c] = 1'b1;
      end
    end else if (st) begin
      m_busy[c]  = 1'b1;
      m_start[c] = edge_n;
      m_addr[c]  = a;
    end
  endfunction
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < 2; c++) begin
        m_busy[c] = 0; m_start[c] = 0; m_addr[c] = '0; m_data[c] = '0; m_done[c] = 0; m_fault[c] = 0;
      end
      m_fetch = '0;
      m_stall = '0;
    end else begin
      edge_n++;
      if (m_busy[0]) m_stall = m_stall + 1;
      step(0, bus.ir_write, bus.pc_addr, bus.imem_valid, bus.imem_rdata);
      step(1, bus.mdr_write, bus.data_addr, bus.dmem_valid, bus.dmem_rdata);
    end
  end
  always @(negedge clk) begin
    chk("imem_req", bus.imem_req, m_busy[0]);
    chk("ir_busy", bus.ir_busy, m_busy[0]);
    chk("imem_addr", bus.imem_addr, m_addr[0]);
    chk("ir_done", bus.ir_done, m_done[0]);
    chk("ir", {bus.opcode, bus.rs, bus.rt, bus.imm}, m_data[0]);
    chk("rd_shamt_funct", {bus.rd, bus.shamt, bus.funct}, m_data[0][15:0]);
    chk("dmem_req", bus.dmem_req, m_busy[1]);
    chk("mdr_busy", bus.mdr_busy, m_busy[1]);
    chk("dmem_addr", bus.dmem_addr, m_addr[1]);
    chk("mdr_done", bus.mdr_done, m_done[1]);
    chk("mdr", bus.mdr, m_data[1]);
    chk("fault", bus.fault, {m_fault[1], m_fault[0]});
`ifdef IRMDR_PERF_EN
    chk("fetch_count", fetch_count, m_fetch);
    chk("stall_count", stall_count, m_stall);
`endif
  end
  function automatic logic [31:0] dut_ir();
    return {bus.opcode, bus.rs, bus.rt, bus.imm};
  endfunction
  int pv_i, pv_d;
  initial begin
    bus.ir_write = 0; bus.mdr_write = 0; bus.pc_addr = '0; bus.data_addr = '0;
    bus.imem_valid = 0; bus.imem_rdata = '0; bus.dmem_valid = 0; bus.dmem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_imem_req", bus.imem_req, 0);
    chk("rst_fault", bus.fault, 0);
    chk("rst_ir", dut_ir(), 0);
    chk("rst_mdr", bus.mdr, 0);
    #2 reset = 0;
    // lw-style fetch with valid on the third edge after launch
    @(negedge clk); bus.ir_write = 1; bus.pc_addr = 32'h40;
    @(negedge clk); bus.ir_write = 0; bus.pc_addr = 32'h9999;
    chk("lw_req", bus.imem_req, 1);
    chk("lw_addr", bus.imem_addr, 32'h40);
    @(negedge clk);
    @(negedge clk); bus.imem_valid = 1; bus.imem_rdata = 32'h8C2A0004;
    chk("lw_addr_held", bus.imem_addr, 32'h40);
    @(negedge clk); bus.imem_valid = 0;
    chk("lw_done", bus.ir_done, 1);
    chk("lw_opcode", bus.opcode, 6'h23);
    chk("lw_rs", bus.rs, 5'd1);
    chk("lw_rt", bus.rt, 5'd10);
    chk("lw_imm", bus.imm, 16'h0004);
    chk("lw_model", m_data[0], 32'h8C2A0004);
    @(negedge clk);
    chk("lw_done_once", bus.ir_done, 0);
    // both channels launched together, data answers first
    @(negedge clk); bus.ir_write = 1; bus.mdr_write = 1; bus.pc_addr = 32'h80; bus.data_addr = 32'h200;
    @(negedge clk); bus.ir_write = 0; bus.mdr_write = 0; bus.dmem_valid = 1; bus.dmem_rdata = 32'hDEADBEEF;
    @(negedge clk); bus.dmem_valid = 0; bus.imem_valid = 1; bus.imem_rdata = 32'h012A4020;
    chk("dual_mdr_done", bus.mdr_done, 1);
    chk("dual_ir_not_done", bus.ir_done, 0);
    chk("dual_mdr", bus.mdr, 32'hDEADBEEF);
    chk("dual_ir_busy", bus.ir_busy, 1);
    @(negedge clk); bus.imem_valid = 0;
    chk("dual_ir_done", bus.ir_done, 1);
    chk("dual_mdr_done_off", bus.mdr_done, 0);
    chk("add_rs", bus.rs, 5'd9);
    chk("add_rd", bus.rd, 5'd8);
    chk("add_funct", bus.funct, 6'h20);
    // data timeout
    @(negedge clk); bus.mdr_write = 1; bus.data_addr = 32'h300;
    @(negedge clk); bus.mdr_write = 0;
    repeat (15) @(negedge clk);
    chk("to_still_busy", bus.mdr_busy, 1);
    chk("to_no_fault_yet", bus.fault, 2'b00);
    @(negedge clk);
    chk("to_fault", bus.fault, 2'b10);
    chk("to_busy", bus.mdr_busy, 0);
    chk("to_req", bus.dmem_req, 0);
    chk("to_mdr_kept", bus.mdr, 32'hDEADBEEF);
    // restart in WAIT and valid in IDLE are both ignored
    @(negedge clk); bus.ir_write = 1; bus.pc_addr = 32'h500;
    @(negedge clk); bus.pc_addr = 32'h600;
    @(negedge clk); bus.ir_write = 0; bus.imem_valid = 1; bus.imem_rdata = 32'h11111111;
    chk("ign_addr", bus.imem_addr, 32'h500);
    @(negedge clk); bus.imem_rdata = 32'h22222222;
    chk("ign_done", bus.ir_done, 1);
    chk("ign_ir", dut_ir(), 32'h11111111);
    @(negedge clk); bus.imem_valid = 0;
    chk("ign_no_done", bus.ir_done, 0);
    chk("ign_ir_kept", dut_ir(), 32'h11111111);
    // asynchronous reset in the middle of a fetch
    @(negedge clk); bus.ir_write = 1; bus.pc_addr = 32'h700;
    @(negedge clk); bus.ir_write = 0;
    #2 reset = 1;
    #1;
    chk("mrst_req", bus.imem_req, 0);
    chk("mrst_fault", bus.fault, 2'b00);
    chk("mrst_ir", dut_ir(), 0);
    @(negedge clk); #2 reset = 0;
    @(negedge clk); bus.ir_write = 1; bus.pc_addr = 32'h704;
    @(negedge clk); bus.ir_write = 0; bus.imem_valid = 1; bus.imem_rdata = 32'hABCD1234;
    @(negedge clk); bus.imem_valid = 0;
    chk("mrst_done", bus.ir_done, 1);
    chk("mrst_ir_new", dut_ir(), 32'hABCD1234);
    chk("mrst_addr", bus.imem_addr, 32'h704);
    chk("mrst_fault_clear", bus.fault, 2'b00);
`ifdef IRMDR_PERF_EN
    @(negedge clk); #2 reset = 1;
    @(negedge clk); #2 reset = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); bus.ir_write = 1; bus.pc_addr = 32'h1000 + 32'(4 * k);
      @(negedge clk); bus.ir_write = 0;
      @(negedge clk); bus.imem_valid = 1; bus.imem_rdata = $urandom;
      @(negedge clk); bus.imem_valid = 0;
    end
    chk("perf_fetch", fetch_count, 32'd4);
    chk("perf_stall", stall_count, 32'd8);
`endif
    // randomized traffic, valid probability re-chosen per window so timeouts also occur
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (i % 700 == 350) #2 reset = 1;
      else if (reset) #2 reset = 0;
      if (i % 50 == 0) begin
        case ($urandom_range(0, 3)) 0: pv_i = 0; 1: pv_i = 10; 2: pv_i = 50; default: pv_i = 100; endcase
        case ($urandom_range(0, 3)) 0: pv_d = 0; 1: pv_d = 10; 2: pv_d = 50; default: pv_d = 100; endcase
      end
      bus.ir_write   = $urandom_range(0, 99) < 30;
      bus.mdr_write  = $urandom_range(0, 99) < 30;
      bus.pc_addr    = $urandom;
      bus.data_addr  = $urandom;
      bus.imem_valid = $urandom_range(0, 99) < pv_i;
      bus.dmem_valid = $urandom_range(0, 99) < pv_d;
      bus.imem_rdata = $urandom;
      bus.dmem_rdata = $urandom;
    end
    @(negedge clk); #2 reset = 0;
    bus.ir_write = 0; bus.mdr_write = 0; bus.imem_valid = 0; bus.dmem_valid = 0;
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/ir_mdr_unit.md
# ir_mdr_unit

Parametrised instruction-register / memory-data-register stage for the multicycle CPU. It replaces the combinational-capture IR/MDR latch with two independent request/valid memory channels, instruction and data, each tolerating variable memory latency and guarded by a timeout. It holds the captured instruction and decodes its MIPS fields, and holds the loaded data word. It sits between the control FSM (which issues `ir_write` / `mdr_write`) and the instruction and data memories.

## Interface
- `ADDR_W`, 32, address width of both memory channels
- `DATA_W`, 32, data width of the MDR; IR is always 32 bits
- `TIMEOUT`, 16, max cycles waiting for `*_valid` before abort (≥1)
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `ir_write`  in  1  start an instruction fetch from `pc_addr`
- `pc_addr`  in  ADDR_W  fetch address, sampled with `ir_write`
- `mdr_write`  in  1  start a data read from `data_addr`
- `data_addr`  in  ADDR_W  load address, sampled with `mdr_write`
- `imem_req` / `imem_addr`  out  1 / ADDR_W  instruction memory request, held until valid or timeout
- `imem_rdata` / `imem_valid`  in  32 / 1  instruction memory response
- `dmem_req` / `dmem_addr`  out  1 / ADDR_W  data memory request
- `dmem_rdata` / `dmem_valid`  in  DATA_W / 1  data memory response
- `ir_busy`, `mdr_busy`  out  1  channel in WAIT
- `ir_done`, `mdr_done`  out  1  one-cycle pulse on capture
- `fault`  out  2  sticky timeout flags {data, instr}
- `opcode` [5:0], `rs` [4:0], `rt` [4:0], `rd` [4:0], `shamt` [4:0], `funct` [5:0], `imm` [15:0]  out  decoded IR fields (IR[31:26], [25:21], [20:16], [15:11], [10:6], [5:0], [15:0])
- `mdr`  out  DATA_W  captured data word

## Operation
- Each channel is a two-state FSM: IDLE → WAIT on start (`ir_write` / `mdr_write`) sampled in IDLE; address registered into `*_addr`; `*_req` = 1 throughout WAIT.
- In WAIT, `*_valid` = 1: capture rdata (IR or MDR), pulse `*_done`, return to IDLE.
- In WAIT, the wait counter reaches TIMEOUT without valid: return to IDLE, set the channel's `fault` bit, leave IR/MDR unchanged, no `*_done`.
- Start asserted in WAIT: ignored. `*_valid` in IDLE: ignored.
- Channels are fully independent. Simultaneous `ir_write` and `mdr_write` both launch in the same cycle.
- `fault` bits are sticky until reset.
- Wait counter is $clog2(TIMEOUT+1) bits, cleared on entering WAIT, saturating.
- Decoded fields are continuous slices of the IR register.
- Reset values: IR=0 (all fields 0), MDR=0, `*_req`=0, `*_addr`=0, `*_busy`=0, `*_done`=0, `fault`=0, both FSMs IDLE.
- Reset mid-WAIT aborts the access. No fault is recorded.

## Timing
- Start sampled at edge N → `*_req`/`*_busy` high after N.
- Valid sampled at edge N+k (k≥1) → IR/MDR and `*_done` update after N+k. `*_req` drops at the same edge.
- Minimum start-to-data latency is 2 edges.
- Timeout: with no valid, abort at edge N+TIMEOUT; `fault` is visible after that edge.
- A new start can be accepted in the cycle after `*_done` (back-to-back every 2 cycles).

## Configuration
- `IRMDR_PERF_EN` defined: adds outputs `fetch_count` [31:0] (completed instruction captures) and `stall_count` [31:0] (cycles with `ir_busy`=1). Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package `irmdr_pkg`: channel state enum (IDLE, WAIT), IR field position/width constants, default TIMEOUT.
- Sub-module `mem_capture_chan` (params ADDR_W, DATA_W, TIMEOUT): one FSM, counter, address/data register, done/fault. Instantiated twice. The top adds only the IR field decode and perf counters.

## Test plan
- Reset mid-WAIT → `imem_req`=0, IR=0, `fault`=2'b00, next `ir_write` accepted normally.
- `ir_write`, `pc_addr`=0x40, `imem_valid` 3 cycles later with 0x8C2A0004 → `imem_addr`=0x40 held, `ir_done` pulses once, opcode=0x23, rs=1, rt=10, imm=0x0004.
- `mdr_write` and `ir_write` same cycle, data valid first → both capture independently, `mdr`=rdata, two separate done pulses.
- No `dmem_valid`, TIMEOUT=16 → abort after 16 edges, `fault`=2'b10, MDR unchanged, `mdr_busy`=0.
- Second `ir_write` during WAIT plus stray `imem_valid` in IDLE → no extra capture, exactly one `ir_done`.
- With `IRMDR_PERF_EN`, 4 fetches at latency 2 → `fetch_count`=4, `stall_count`=8.
